// File: rtl/bcm_row_scheduler_if.sv
// rtl/bcm_row_scheduler_if.sv - shifter, BCM timer and panel control bundle for the row scheduler
interface bcm_row_scheduler_if #(
  parameter int ROWS       = 16,
  parameter int RESOLUTION = 3
);
  localparam int PW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
  localparam int RW = $clog2(ROWS);

  logic          in_ENABLE;
  logic          in_SHIFT_DONE;
  logic          in_BCM_NEXT_PLANE;
  logic          in_BCM_FINISHED;
  logic          in_BCM_DIM;
  logic          out_SHIFT_START;
  logic [PW-1:0] out_PLANE;
  logic [RW-1:0] out_ROW_NEXT;
  logic [RW-1:0] out_ROW_ADDR;
  logic          out_LATCH;
  logic          out_OE_N;
  logic          out_BCM_RST;
  logic          out_BCM_INIT;
  logic          out_BCM_CONTINUE;
  logic          out_FRAME_DONE;

  // scheduler side
  modport master (
    input  in_ENABLE, in_SHIFT_DONE, in_BCM_NEXT_PLANE, in_BCM_FINISHED, in_BCM_DIM,
    output out_SHIFT_START, out_PLANE, out_ROW_NEXT, out_ROW_ADDR, out_LATCH, out_OE_N,
           out_BCM_RST, out_BCM_INIT, out_BCM_CONTINUE, out_FRAME_DONE
  );

  // shifter / BCM timer / panel side
  modport slave (
    output in_ENABLE, in_SHIFT_DONE, in_BCM_NEXT_PLANE, in_BCM_FINISHED, in_BCM_DIM,
    input  out_SHIFT_START, out_PLANE, out_ROW_NEXT, out_ROW_ADDR, out_LATCH, out_OE_N,
           out_BCM_RST, out_BCM_INIT, out_BCM_CONTINUE, out_FRAME_DONE
  );
endinterface

// File: rtl/bcm_row_scheduler.sv
// rtl/bcm_row_scheduler.sv - BCM row refresh sequencer driving the row shifter, BCM timer and panel pins
module bcm_row_scheduler #(
  parameter int ROWS       = 16,
  parameter int RESOLUTION = 3
) (
  input logic                  clk,
  input logic                  rst,
  bcm_row_scheduler_if.master  bus
);
  localparam int PW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
  localparam int RW = $clog2(ROWS);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SHIFT_REQ  = 3'd1;
  localparam logic [2:0] SHIFT_WAIT = 3'd2;
  localparam logic [2:0] LATCH      = 3'd3;
  localparam logic [2:0] SHOW       = 3'd4;
  localparam logic [2:0] ROW_END    = 3'd5;

  localparam logic [PW-1:0] PLANE_LAST = PW'(RESOLUTION - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  logic [2:0]    state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] row_addr_q, row_addr_d;
  logic [PW-1:0] plane_q, plane_d;
  logic          first_q, first_d;
  logic          shift_start_q, shift_start_d;
  logic          latch_q, latch_d;
  logic          oe_n_q, oe_n_d;
  logic          bcm_rst_q, bcm_rst_d;
  logic          bcm_init_q, bcm_init_d;
  logic          bcm_cont_q, bcm_cont_d;
  logic          frame_done_q, frame_done_d;

  // Next-state and next-output logic; every output is a register loaded from here,
  // so each strobe is high exactly in the cycle its state is occupied.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    row_addr_d    = row_addr_q;
    plane_d       = plane_q;
    first_d       = 1'b0;
    shift_start_d = 1'b0;
    latch_d       = 1'b0;
    oe_n_d        = 1'b1;
    bcm_rst_d     = bcm_rst_q;
    bcm_init_d    = 1'b0;
    bcm_cont_d    = 1'b0;
    frame_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        bcm_rst_d = 1'b1;
        if (bus.in_ENABLE) begin
          state_d       = SHIFT_REQ;
          plane_d       = '0;
          shift_start_d = 1'b1;
          bcm_rst_d     = 1'b0;
        end
      end
      SHIFT_REQ: begin
        // a done pulse coincident with the request belongs to an older transfer
        state_d = SHIFT_WAIT;
      end
      SHIFT_WAIT: begin
        if (bus.in_SHIFT_DONE) begin
          state_d = LATCH;
          latch_d = 1'b1;
          // the panel row changes only together with the first plane's latch
          if (plane_q == '0) begin
            row_addr_d = row_q;
          end
        end
      end
      LATCH: begin
        state_d = SHOW;
        first_d = 1'b1;
        if (plane_q == '0) begin
          bcm_init_d = 1'b1;
        end else begin
          bcm_cont_d = 1'b1;
        end
      end
      SHOW: begin
        oe_n_d = bus.in_BCM_DIM;
        // BCM events are only trusted once the timer has seen our INIT/CONTINUE
        if (!first_q) begin
          if (bus.in_BCM_FINISHED) begin
            state_d      = ROW_END;
            oe_n_d       = 1'b1;
            bcm_rst_d    = 1'b1;
            plane_d      = '0;
            row_d        = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            frame_done_d = (row_q == ROW_LAST);
          end else if (bus.in_BCM_NEXT_PLANE && (plane_q != PLANE_LAST)) begin
            state_d       = SHIFT_REQ;
            oe_n_d        = 1'b1;
            plane_d       = plane_q + PW'(1);
            shift_start_d = 1'b1;
          end
        end
      end
      ROW_END: begin
        if (bus.in_ENABLE) begin
          state_d       = SHIFT_REQ;
          shift_start_d = 1'b1;
          bcm_rst_d     = 1'b0;
        end else begin
          state_d   = IDLE;
          bcm_rst_d = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        bcm_rst_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      row_q         <= '0;
      row_addr_q    <= '0;
      plane_q       <= '0;
      first_q       <= 1'b0;
      shift_start_q <= 1'b0;
      latch_q       <= 1'b0;
      oe_n_q        <= 1'b1;
      bcm_rst_q     <= 1'b1;
      bcm_init_q    <= 1'b0;
      bcm_cont_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      row_addr_q    <= row_addr_d;
      plane_q       <= plane_d;
      first_q       <= first_d;
      shift_start_q <= shift_start_d;
      latch_q       <= latch_d;
      oe_n_q        <= oe_n_d;
      bcm_rst_q     <= bcm_rst_d;
      bcm_init_q    <= bcm_init_d;
      bcm_cont_q    <= bcm_cont_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.out_SHIFT_START  = shift_start_q;
  assign bus.out_PLANE        = plane_q;
  assign bus.out_ROW_NEXT     = row_q;
  assign bus.out_ROW_ADDR     = row_addr_q;
  assign bus.out_LATCH        = latch_q;
  assign bus.out_OE_N         = oe_n_q;
  assign bus.out_BCM_RST      = bcm_rst_q;
  assign bus.out_BCM_INIT     = bcm_init_q;
  assign bus.out_BCM_CONTINUE = bcm_cont_q;
  assign bus.out_FRAME_DONE   = frame_done_q;
endmodule
